dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer for the byte-wide data memory. It shares a single byte-wide synchronous RAM between the multi-cycle CPU (port C) and a host/loader port (port H), which preloads matrix/vector operands and reads back results. Each granted request is a full 32-bit big-endian word access, sequenced as four byte cycles on the memory port, followed by a one-cycle response pulse.

## Interface
- ADDR_WIDTH, 8: byte address width; 256 bytes covers a 3x4 matrix, a 4-element vector and a 3-word result.
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- c_req_valid / h_req_valid  in  1  request present on port C / H.
- c_req_ready / h_req_ready  out  1  request accepted this cycle; combinational.
- c_req_we / h_req_we  in  1  1 = write word, 0 = read word.
- c_req_addr / h_req_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored, so accesses are word-aligned.
- c_req_wdata / h_req_wdata  in  32  write word.
- c_resp_valid / h_resp_valid  out  1  one-cycle completion pulse.
- c_resp_rdata / h_resp_rdata  out  32  read word; valid with resp_valid; 0 for writes.
- mem_addr  out  ADDR_WIDTH  RAM byte address.
- mem_we  out  1  RAM byte write enable.
- mem_wdata  out  8  RAM write byte.
- mem_rdata  in  8  RAM read byte; registered RAM, valid one cycle after mem_addr.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: ready is asserted only here, to the arbitration winner, and only while that port's valid is high. Handshake is valid && ready; the handshake latches we, base address (addr & ~3) and wdata, then moves to XFER with k=0.
  - XFER: mem_addr = base+k, k = 0..3. Byte k is bits [31-8k -: 8], big-endian, so byte 0 is the MSB. Writes drive mem_we=1 and mem_wdata = byte k. After k=3: a write goes to RESP; a read goes to DRAIN.
  - DRAIN (read only): captures the final byte, then goes to RESP.
  - RESP: the owning port's resp_valid=1 with rdata. Return to IDLE.
- Read assembly: the mem_rdata byte captured in cycle t belongs to the address driven in cycle t-1.
- Arbitration when both valid in IDLE: round-robin. Grant goes to the port not served last. The last-served pointer resets to H, so C wins the first tie. With a single valid, that port wins.
- A requester may drop valid before its handshake; no transaction results. After the handshake, the request inputs are don't-care.
- Responses have no backpressure. Requesters must accept the pulse.
- Reset mid-operation: the FSM returns to IDLE on the next edge and mem_we falls. Bytes already written stay in RAM. No resp is issued; the requester must reissue.
- The address does not wrap within a word, because base+3 never carries out of bits [1:0].

## Timing
- Reset values: resp_valid=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, state IDLE, pointer=H. Both ready=0 while reset is high.
- Handshake in cycle T:
  - XFER in T+1..T+4.
  - Write: resp_valid in T+5.
  - Read: DRAIN in T+5, resp_valid in T+6.
- Earliest next handshake: T+6 for a write, T+7 for a read (the IDLE cycle after RESP).
- Throughput: one word per 6 cycles (write) or 7 cycles (read).

## Configuration
- DMEM_ARB_FIXED_PRIO_EN defined: port C always wins ties, and the pointer is unused. This keeps CPU latency deterministic for clock_count/CPI measurement.
- Undefined: round-robin as above.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, XFER, DRAIN, RESP);
  - port index constants PORT_C=0, PORT_H=1;
  - BYTES_PER_WORD=4.
- Sub-module rr_arbiter2: two request inputs, a grant vector, an update strobe, and the last-served pointer register. The fixed-priority macro is resolved inside it.

## Test plan
- Reset, then a single H write of 0x12345678 to address 0x00 → mem_we high T+1..T+4, bytes 0x12, 0x34, 0x56, 0x78 at 0x00..0x03; h_resp_valid in T+5; busy low in T+6.
- H read of 0x00 after that write → h_resp_valid in T+6 with h_resp_rdata=0x12345678. Address 0x02 returns the same word (alignment).
- C and H both valid in the first IDLE after reset → C granted first. H is held and granted at the next IDLE, and both complete. A second simultaneous pair → H granted first. With DMEM_ARB_FIXED_PRIO_EN, C wins both times.
- Load a 3x4 matrix, 4-element vector and 3-word result region via H at 0x00/0x30/0x40. C reads back 0x40..0x48 → words match the writes; no resp is ever delivered to the wrong port.
- Reset asserted at T+2 of an H write of 0xAABBCCDD to 0x10 → no h_resp_valid. RAM 0x10=0xAA and 0x11=0xBB, with 0x12/0x13 unchanged. A new request is accepted the cycle after reset deasserts.
- H valid dropped before its grant (C busy) → no H transaction and no h_resp_valid.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Word/byte ordering helper: byte 0 of a word is its most significant byte.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int PORT_C         = 0;
    localparam int PORT_H         = 1;
    localparam int BYTES_PER_WORD = 4;

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: word request plus response pulse.
// Request is valid/ready; the response pulse has no backpressure.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way arbiter, combinational grant; pointer updates on the update strobe.
// DMEM_ARB_FIXED_PRIO_EN: port C always wins ties and the pointer is removed.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, reset, update};

    always_comb begin
        grant = 2'b00;
        if (req[PORT_C])
            grant[PORT_C] = 1'b1;
        else if (req[PORT_H])
            grant[PORT_H] = 1'b1;
    end
`else
    // last_h: 1 when port H was the most recently served requester
    logic last_h;

    always_ff @(posedge clk) begin
        if (reset)
            last_h <= 1'b1;
        else if (update)
            last_h <= grant[PORT_H];
    end

    always_comb begin
        grant = 2'b00;
        if (req[PORT_C] && req[PORT_H]) begin
            if (last_h)
                grant[PORT_C] = 1'b1;
            else
                grant[PORT_H] = 1'b1;
        end else begin
            grant = req;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a byte-wide registered RAM between CPU (C) and host (H) as 32-bit big-endian words;
// write resp at T+5, read resp at T+6 after handshake T; responses unthrottled. Macro: DMEM_ARB_FIXED_PRIO_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    dmem_arbiter_if.slave         c,
    dmem_arbiter_if.slave         h,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    output logic                  busy
);

    state_e                state;
    logic [1:0]            k;
    logic                  owner_h;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;

    logic [1:0]            req;
    logic [1:0]            grant;
    logic                  hs;
    logic                  in_idle;
    logic                  xfer;

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [31:0]           sel_wdata;

    assign req[PORT_C] = c.req_valid;
    assign req[PORT_H] = h.req_valid;

    rr_arbiter2 u_arb (
        .clk    (CLOCK_50),
        .reset  (reset),
        .req    (req),
        .update (hs),
        .grant  (grant)
    );

    assign in_idle     = (state == ST_IDLE) && !reset;
    assign c.req_ready = in_idle && grant[PORT_C];
    assign h.req_ready = in_idle && grant[PORT_H];
    assign hs          = c.req_ready || h.req_ready;

    always_comb begin
        sel_we    = c.req_we;
        sel_addr  = c.req_addr;
        sel_wdata = c.req_wdata;
        if (grant[PORT_H]) begin
            sel_we    = h.req_we;
            sel_addr  = h.req_addr;
            sel_wdata = h.req_wdata;
        end
    end

    // RAM is registered: a byte arrives one cycle after its address, so the
    // first capture is at k=1 and the last one happens in DRAIN.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= ST_IDLE;
            k       <= 2'd0;
            owner_h <= 1'b0;
            we_q    <= 1'b0;
            base    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hs) begin
                        owner_h <= grant[PORT_H];
                        we_q    <= sel_we;
                        base    <= {sel_addr[ADDR_WIDTH-1:2], 2'b00};
                        wdata_q <= sel_wdata;
                        rdata_q <= '0;
                        k       <= 2'd0;
                        state   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (!we_q && k != 2'd0)
                        rdata_q <= {rdata_q[23:0], mem_rdata};
                    k <= k + 2'd1;
                    if (k == 2'd3)
                        state <= we_q ? ST_RESP : ST_DRAIN;
                end
                ST_DRAIN: begin
                    rdata_q <= {rdata_q[23:0], mem_rdata};
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign xfer      = (state == ST_XFER);
    assign mem_addr  = xfer ? (base | {{(ADDR_WIDTH-2){1'b0}}, k}) : '0;
    assign mem_we    = xfer && we_q;
    assign mem_wdata = (xfer && we_q) ? word_byte(wdata_q, k) : 8'h00;
    assign busy      = (state != ST_IDLE);

    assign c.resp_valid = (state == ST_RESP) && !owner_h;
    assign h.resp_valid = (state == ST_RESP) && owner_h;
    assign c.resp_rdata = c.resp_valid ? rdata_q : 32'h0;
    assign h.resp_rdata = h.resp_valid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered byte RAM model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;

    dmem_arbiter_if #(.ADDR_WIDTH(8)) c_if ();
    dmem_arbiter_if #(.ADDR_WIDTH(8)) h_if ();

    dmem_arbiter #(.ADDR_WIDTH(8)) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .c         (c_if),
        .h         (h_if),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int c_resp_cnt = 0;
    int h_resp_cnt = 0;
    always @(posedge clk) begin
        if (c_if.resp_valid) c_resp_cnt <= c_resp_cnt + 1;
        if (h_if.resp_valid) h_resp_cnt <= h_resp_cnt + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gen(input int j);
        return {8'hA0 ^ 8'(j), 8'(j * 3), 8'(j + 17), 8'hC3 ^ 8'(j * 7)};
    endfunction

    task automatic drive(input bit port, input bit v, input bit we, input logic [7:0] a, input logic [31:0] d);
        if (port) begin
            h_if.req_valid = v; h_if.req_we = we; h_if.req_addr = a; h_if.req_wdata = d;
        end else begin
            c_if.req_valid = v; c_if.req_we = we; c_if.req_addr = a; c_if.req_wdata = d;
        end
    endtask

    // Called at a negedge; handshake, then waits for the owner's response pulse.
    task automatic xact(input bit port, input bit we, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat, output int nwait);
        int wrong;
        logic rdy;
        drive(port, 1'b1, we, a, d);
        nwait = 0;
        forever begin
            #1;
            rdy = port ? h_if.req_ready : c_if.req_ready;
            if (rdy || nwait >= 40) break;
            @(negedge clk);
            nwait++;
        end
        chk("grant", 32'(rdy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(port, 1'b0, 1'b0, 8'h00, 32'h0);
        lat = 1;
        wrong = 0;
        rd = 32'hxxxxxxxx;
        while (lat <= 10) begin
            if (port ? c_if.resp_valid : h_if.resp_valid) wrong++;
            if (port ? h_if.resp_valid : c_if.resp_valid) begin
                rd = port ? h_if.resp_rdata : c_if.resp_rdata;
                break;
            end
            @(negedge clk);
            lat++;
        end
        chk("wrong_port_resp", 32'(wrong), 32'd0);
        @(negedge clk);
    endtask

    logic [31:0] rd, w, orig;
    int lat, nw, n, c0, h0, seen;
    bit first_h;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 8'h00, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_h_ready", 32'(h_if.req_ready), 32'd0);
        chk("rst_c_resp", 32'(c_if.resp_valid), 32'd0);
        chk("rst_h_resp", 32'(h_if.resp_valid), 32'd0);
        chk("rst_h_rdata", h_if.resp_rdata, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Single H write, cycle-by-cycle memory port check
        w = 32'h12345678;
        drive(1'b1, 1'b1, 1'b1, 8'h00, w);
        #1 chk("wr_h_ready", 32'(h_if.req_ready), 32'd1);
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
            chk("wr_mem_we", 32'(mem_we), 32'd1);
            chk("wr_mem_addr", 32'(mem_addr), 32'(k));
            chk("wr_mem_wdata", 32'(mem_wdata), 32'(w[31-8*k -: 8]));
        end
        @(negedge clk);
        chk("wr_h_resp", 32'(h_if.resp_valid), 32'd1);
        chk("wr_h_rdata", h_if.resp_rdata, 32'd0);
        chk("wr_c_resp", 32'(c_if.resp_valid), 32'd0);
        @(negedge clk);
        chk("wr_busy_after", 32'(busy), 32'd0);
        chk("wr_ram1", 32'(ram[1]), 32'h34);

        xact(1'b1, 1'b0, 8'h00, 32'h0, rd, lat, nw);
        chk("rd0_data", rd, 32'h12345678);
        chk("rd0_lat", 32'(lat), 32'd6);
        xact(1'b1, 1'b0, 8'h02, 32'h0, rd, lat, nw);
        chk("rd2_align", rd, 32'h12345678);

        // Tie after reset, then C re-requests while H still waits
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 8'h80, 32'hC0C0C0C0);
        drive(1'b1, 1'b1, 1'b1, 8'h84, 32'h4B4B4B4B);
        #1;
        chk("tie1_c_ready", 32'(c_if.req_ready), 32'd1);
        chk("tie1_h_ready", 32'(h_if.req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 8'h88, 32'hC1C1C1C1);
        n = 1;
        while (n < 20) begin
            #1;
            if (c_if.req_ready || h_if.req_ready) break;
            @(negedge clk);
            n++;
        end
        chk("tie2_gap", 32'(n), 32'd6);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        chk("tie2_h_ready", 32'(h_if.req_ready), 32'd0);
        chk("tie2_c_ready", 32'(c_if.req_ready), 32'd1);
`else
        chk("tie2_h_ready", 32'(h_if.req_ready), 32'd1);
        chk("tie2_c_ready", 32'(c_if.req_ready), 32'd0);
`endif
        first_h = h_if.req_ready;
        @(posedge clk);
        @(negedge clk);
        if (first_h) drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        else         drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        n = 1;
        while (n < 20) begin
            #1;
            if (c_if.req_ready || h_if.req_ready) break;
            @(negedge clk);
            n++;
        end
        chk("tie3_gap", 32'(n), 32'd6);
        chk("tie3_other", 32'(first_h ? c_if.req_ready : h_if.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        repeat (6) @(negedge clk);
        chk("tie_c_resps", 32'(c_resp_cnt), 32'd2);
        chk("tie_h_resps", 32'(h_resp_cnt), 32'd4);
        xact(1'b1, 1'b0, 8'h80, 32'h0, rd, lat, nw);
        chk("tie_rd80", rd, 32'hC0C0C0C0);
        xact(1'b1, 1'b0, 8'h84, 32'h0, rd, lat, nw);
        chk("tie_rd84", rd, 32'h4B4B4B4B);
        xact(1'b1, 1'b0, 8'h88, 32'h0, rd, lat, nw);
        chk("tie_rd88", rd, 32'hC1C1C1C1);

        // Matrix 0x00, vector 0x30, result region 0x40 via H; C reads back
        for (int j = 0; j < 12; j++) begin
            xact(1'b1, 1'b1, 8'(j * 4), gen(j), rd, lat, nw);
            chk("mat_wr_lat", 32'(lat), 32'd5);
        end
        for (int j = 12; j < 16; j++) xact(1'b1, 1'b1, 8'(8'h30 + (j - 12) * 4), gen(j), rd, lat, nw);
        for (int j = 16; j < 19; j++) xact(1'b1, 1'b1, 8'(8'h40 + (j - 16) * 4), gen(j), rd, lat, nw);
        for (int j = 16; j < 19; j++) begin
            xact(1'b0, 1'b0, 8'(8'h40 + (j - 16) * 4), 32'h0, rd, lat, nw);
            chk("c_rd_res", rd, gen(j));
            chk("c_rd_lat", 32'(lat), 32'd6);
        end
        xact(1'b0, 1'b0, 8'h34, 32'h0, rd, lat, nw);
        chk("c_rd_vec", rd, gen(13));

        // Reset during the third cycle of an H write
        orig = gen(4);
        h0 = h_resp_cnt;
        drive(1'b1, 1'b1, 1'b1, 8'h10, 32'hAABBCCDD);
        #1 chk("rst_mid_ready", 32'(h_if.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_we", 32'(mem_we), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_noresp", 32'(h_resp_cnt - h0), 32'd0);
        xact(1'b1, 1'b0, 8'h10, 32'h0, rd, lat, nw);
        chk("rst_mid_accept", 32'(nw), 32'd0);
        chk("rst_mid_word", rd, {16'hAABB, orig[15:0]});
        chk("rst_mid_resps", 32'(h_resp_cnt - h0), 32'd1);

        // H gives up while C owns the memory
        c0 = c_resp_cnt;
        h0 = h_resp_cnt;
        seen = 0;
        drive(1'b0, 1'b1, 1'b0, 8'h40, 32'h0);
        #1 chk("drop_c_ready", 32'(c_if.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 8'h20, 32'hDEADBEEF);
        repeat (2) begin
            #1 if (h_if.req_ready) seen++;
            @(negedge clk);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        repeat (8) begin
            #1 if (h_if.req_ready) seen++;
            @(negedge clk);
        end
        chk("drop_h_never_ready", 32'(seen), 32'd0);
        chk("drop_h_noresp", 32'(h_resp_cnt - h0), 32'd0);
        chk("drop_c_resp", 32'(c_resp_cnt - c0), 32'd1);
        xact(1'b0, 1'b0, 8'h20, 32'h0, rd, lat, nw);
        chk("drop_ram_intact", rd, gen(8));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
